rs_age_ordered: RTL and testbench

- Parametrised, next-generation reservation station between decoder/register file and one ALU.
- Holds up to DEPTH in-flight ops with two renamed source operands each.
- Wakes operands from N_BCAST parallel result broadcasts and issues the oldest fully ready op through a valid/ready output register.
- Adds over the previous generation: dispatch/issue handshakes, multi-channel wakeup, same-cycle dispatch bypass, age-ordered (not index-ordered) issue, occupancy count.

---
 rtl/rs_age_ordered_pkg.sv | 18 +
 rtl/rs_age_picker.sv | 28 ++
 rtl/rs_age_ordered.sv | 178 +++++++++++++++++
 tb/tb_rs_age_ordered.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_age_ordered_pkg.sv
// Shared constants for the age-ordered reservation station: boolean levels,
// the "value present" tag and default widths.
package rs_age_ordered_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int TAG_NONE = 0;

  localparam int DEF_DEPTH     = 8;
  localparam int DEF_IDX_W     = 3;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_TAG_W     = 32;
  localparam int DEF_OP_W      = 6;
  localparam int DEF_N_BCAST   = 2;
  localparam int DEF_AF_MARGIN = 3;

endpackage

// File: rtl/rs_age_picker.sv
// Combinational oldest-ready selector: grants the ready entry that no other
// ready entry is older than.
module rs_age_picker
  import rs_age_ordered_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
  output logic [DEPTH-1:0]            grant,
  output logic                        found
);

  always_comb begin
    logic [DEPTH-1:0] col;
    grant = '0;
    col   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        col[j] = older[j][i];
      end
      grant[i] = ready[i] && ((ready & col) == '0);
    end
  end

  assign found = |ready;

endmodule

// File: rtl/rs_age_ordered.sv
// Reservation station with multi-channel wakeup, dispatch bypass and
// age-ordered issue into a valid/ready output register.
module rs_age_ordered
  import rs_age_ordered_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int IDX_W     = DEF_IDX_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TAG_W     = DEF_TAG_W,
  parameter int OP_W      = DEF_OP_W,
  parameter int N_BCAST   = DEF_N_BCAST,
  parameter int AF_MARGIN = DEF_AF_MARGIN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [OP_W-1:0]           disp_op,
  input  logic [DATA_W-1:0]         disp_pc,
  input  logic [DATA_W-1:0]         disp_imm,
  input  logic [TAG_W-1:0]          disp_q1,
  input  logic [TAG_W-1:0]          disp_q2,
  input  logic [DATA_W-1:0]         disp_v1,
  input  logic [DATA_W-1:0]         disp_v2,
  input  logic [N_BCAST-1:0]        bc_valid,
  input  logic [N_BCAST*TAG_W-1:0]  bc_tag,
  input  logic [N_BCAST*DATA_W-1:0] bc_data,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [OP_W-1:0]           iss_op,
  output logic [DATA_W-1:0]         iss_v1,
  output logic [DATA_W-1:0]         iss_v2,
  output logic [DATA_W-1:0]         iss_imm,
  output logic [DATA_W-1:0]         iss_pc,
  output logic [IDX_W:0]            count,
  output logic                      almost_full
);

  localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] NO_TAG     = TAG_W'(TAG_NONE);

  logic [DEPTH-1:0]            busy;
  logic [DEPTH-1:0][DEPTH-1:0] older;
  logic [OP_W-1:0]             e_op  [DEPTH];
  logic [DATA_W-1:0]           e_pc  [DEPTH];
  logic [DATA_W-1:0]           e_imm [DEPTH];
  logic [DATA_W-1:0]           e_v1  [DEPTH];
  logic [DATA_W-1:0]           e_v2  [DEPTH];
  logic [TAG_W-1:0]            e_q1  [DEPTH];
  logic [TAG_W-1:0]            e_q2  [DEPTH];

  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] grant;
  logic [DEPTH-1:0] busy_after;
  logic             found;
  logic             load;
  logic             move;
  logic             accept;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] free_idx;
  logic [DATA_W:0]  wake1 [DEPTH];
  logic [DATA_W:0]  wake2 [DEPTH];
  logic [DATA_W:0]  disp_w1;
  logic [DATA_W:0]  disp_w2;

  // Returns {hit, data}; scanning downwards lets the lowest channel win.
  function automatic logic [DATA_W:0] bc_lookup(input logic [TAG_W-1:0] tag);
    bc_lookup = '0;
    for (int c = N_BCAST-1; c >= 0; c--) begin
      if (bc_valid[c] && tag != NO_TAG && bc_tag[c*TAG_W +: TAG_W] == tag)
        bc_lookup = {TRUE, bc_data[c*DATA_W +: DATA_W]};
    end
  endfunction

  assign disp_ready  = (count != FULL_COUNT);
  assign almost_full = (int'(count) + AF_MARGIN >= DEPTH);
  assign accept      = disp_valid && disp_ready;
  assign load        = !iss_valid || iss_ready;
  assign move        = load && found;
  assign busy_after  = busy & ~(grant & {DEPTH{move}});
  assign disp_w1     = bc_lookup(disp_q1);
  assign disp_w2     = bc_lookup(disp_q2);

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = busy[i] && e_q1[i] == NO_TAG && e_q2[i] == NO_TAG;
      wake1[i]     = bc_lookup(e_q1[i]);
      wake2[i]     = bc_lookup(e_q2[i]);
    end
  end

  always_comb begin
    sel      = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel = IDX_W'(i);
    end
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

  rs_age_picker #(.DEPTH(DEPTH)) u_picker (
    .ready (ready_vec),
    .older (older),
    .grant (grant),
    .found (found)
  );

  // A new entry is younger than everything still resident after this edge's issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= '0;
      older     <= '0;
      count     <= '0;
      iss_valid <= FALSE;
      iss_op    <= '0;
      iss_v1    <= '0;
      iss_v2    <= '0;
      iss_imm   <= '0;
      iss_pc    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_op[i]  <= '0;
        e_pc[i]  <= '0;
        e_imm[i] <= '0;
        e_v1[i]  <= '0;
        e_v2[i]  <= '0;
        e_q1[i]  <= '0;
        e_q2[i]  <= '0;
      end
    end else if (flush) begin
      busy      <= '0;
      older     <= '0;
      count     <= '0;
      iss_valid <= FALSE;
    end else begin
      if (load) begin
        iss_valid <= found;
        if (found) begin
          iss_op  <= e_op[sel];
          iss_v1  <= e_v1[sel];
          iss_v2  <= e_v2[sel];
          iss_imm <= e_imm[sel];
          iss_pc  <= e_pc[sel];
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && wake1[i][DATA_W]) begin
          e_q1[i] <= NO_TAG;
          e_v1[i] <= wake1[i][DATA_W-1:0];
        end
        if (busy[i] && wake2[i][DATA_W]) begin
          e_q2[i] <= NO_TAG;
          e_v2[i] <= wake2[i][DATA_W-1:0];
        end
      end
      if (move) busy[sel] <= FALSE;
      if (accept) begin
        busy[free_idx]  <= TRUE;
        e_op[free_idx]  <= disp_op;
        e_pc[free_idx]  <= disp_pc;
        e_imm[free_idx] <= disp_imm;
        e_q1[free_idx]  <= disp_w1[DATA_W] ? NO_TAG : disp_q1;
        e_v1[free_idx]  <= disp_w1[DATA_W] ? disp_w1[DATA_W-1:0] : disp_v1;
        e_q2[free_idx]  <= disp_w2[DATA_W] ? NO_TAG : disp_q2;
        e_v2[free_idx]  <= disp_w2[DATA_W] ? disp_w2[DATA_W-1:0] : disp_v2;
        for (int k = 0; k < DEPTH; k++) begin
          older[k][free_idx] <= busy_after[k];
          older[free_idx][k] <= FALSE;
        end
      end
      count <= count + (IDX_W+1)'(accept) - (IDX_W+1)'(move);
    end
  end

endmodule

// File: tb/tb_rs_age_ordered.sv
// Self-checking bench for rs_age_ordered: directed scenarios plus a randomized
// run against a queue-based age-order reference model.
module tb_rs_age_ordered;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [5:0]  disp_op;
  logic [31:0] disp_pc, disp_imm, disp_q1, disp_q2, disp_v1, disp_v2;
  logic [1:0]  bc_valid;
  logic [63:0] bc_tag, bc_data;
  logic        iss_valid;
  logic        iss_ready;
  logic [5:0]  iss_op;
  logic [31:0] iss_v1, iss_v2, iss_imm, iss_pc;
  logic [3:0]  count;
  logic        almost_full;

  int total = 0;
  int bad   = 0;

  rs_age_ordered dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .disp_valid  (disp_valid),
    .disp_ready  (disp_ready),
    .disp_op     (disp_op),
    .disp_pc     (disp_pc),
    .disp_imm    (disp_imm),
    .disp_q1     (disp_q1),
    .disp_q2     (disp_q2),
    .disp_v1     (disp_v1),
    .disp_v2     (disp_v2),
    .bc_valid    (bc_valid),
    .bc_tag      (bc_tag),
    .bc_data     (bc_data),
    .iss_valid   (iss_valid),
    .iss_ready   (iss_ready),
    .iss_op      (iss_op),
    .iss_v1      (iss_v1),
    .iss_v2      (iss_v2),
    .iss_imm     (iss_imm),
    .iss_pc      (iss_pc),
    .count       (count),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the queue is kept in dispatch order, so index 0 is oldest.
  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] pc, imm, q1, v1, q2, v2;
  } ent_t;

  ent_t mq[$];
  logic m_valid;
  ent_t m_out;

  function automatic logic [32:0] m_lookup(input logic [31:0] tag);
    for (int c = 0; c < 2; c++) begin
      if (bc_valid[c] && tag != 0 && bc_tag[c*32 +: 32] == tag)
        return {1'b1, bc_data[c*32 +: 32]};
    end
    return '0;
  endfunction

  task automatic model_step();
    logic  acc;
    logic  hit;
    logic [32:0] w;
    ent_t e;
    if (!rst || flush) begin
      mq.delete();
      m_valid = 1'b0;
      if (!rst) m_out = '0;
      return;
    end
    acc = disp_valid && (mq.size() != 8);
    if (!m_valid || iss_ready) begin
      hit = 1'b0;
      for (int k = 0; k < mq.size(); k++) begin
        if (!hit && mq[k].q1 == 0 && mq[k].q2 == 0) begin
          hit   = 1'b1;
          m_out = mq[k];
          mq.delete(k);
          break;
        end
      end
      m_valid = hit;
    end
    for (int k = 0; k < mq.size(); k++) begin
      e = mq[k];
      w = m_lookup(e.q1);
      if (w[32]) begin e.q1 = 0; e.v1 = w[31:0]; end
      w = m_lookup(e.q2);
      if (w[32]) begin e.q2 = 0; e.v2 = w[31:0]; end
      mq[k] = e;
    end
    if (acc) begin
      e = '{op: disp_op, pc: disp_pc, imm: disp_imm,
            q1: disp_q1, v1: disp_v1, q2: disp_q2, v2: disp_v2};
      w = m_lookup(disp_q1);
      if (w[32]) begin e.q1 = 0; e.v1 = w[31:0]; end
      w = m_lookup(disp_q2);
      if (w[32]) begin e.q2 = 0; e.v2 = w[31:0]; end
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush      = 1'b0;
    disp_valid = 1'b0;
    bc_valid   = '0;
    bc_tag     = '0;
    bc_data    = '0;
  endtask

  task automatic drive_disp(input logic [31:0] pc, input logic [31:0] q1, input logic [31:0] v1,
                            input logic [31:0] q2, input logic [31:0] v2);
    disp_valid = 1'b1;
    disp_op    = pc[5:0];
    disp_pc    = pc;
    disp_imm   = pc ^ 32'h00ff_00ff;
    disp_q1    = q1;
    disp_v1    = v1;
    disp_q2    = q2;
    disp_v2    = v2;
  endtask

  task automatic drain();
    idle();
    iss_ready = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    iss_ready = 1'b0;
    idle();
    drive_disp(0, 0, 0, 0, 0);
    disp_valid = 1'b0;
    tick();
    tick();
    total++;
    if (iss_valid !== 1'b0 || count !== 4'd0 || almost_full !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_state got v=%b c=%0d af=%b exp v=0 c=0 af=0", iss_valid, count, almost_full);
    end
    total++;
    if ({iss_op, iss_v1, iss_v2, iss_imm, iss_pc} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_fields got pc=%h v1=%h exp all zero", iss_pc, iss_v1);
    end
    rst = 1'b1;
    #1;
    total++;
    if (disp_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_disp_ready got=%b exp=1", disp_ready);
    end
  endtask

  task automatic test_basic();
    iss_ready = 1'b1;
    drive_disp(32'h100, 0, 5, 0, 7);
    tick();
    idle();
    tick();
    total++;
    if (iss_valid !== 1'b1 || iss_v1 !== 32'd5 || iss_v2 !== 32'd7 || iss_pc !== 32'h100) begin
      bad++;
      $display("[TB] FAIL basic_issue got v=%b v1=%h v2=%h pc=%h exp v=1 v1=5 v2=7 pc=100",
               iss_valid, iss_v1, iss_v2, iss_pc);
    end
    total++;
    if (count !== 4'd0) begin
      bad++;
      $display("[TB] FAIL basic_count got=%0d exp=0", count);
    end
  endtask

  task automatic test_age();
    drain();
    drive_disp(32'h2f0, 32'h20, 0, 0, 32'h11);
    tick();
    drive_disp(32'h300, 0, 32'h33, 0, 32'h44);
    tick();
    idle();
    bc_valid = 2'b10;
    bc_tag   = {32'h20, 32'h0};
    bc_data  = {32'h55, 32'h0};
    tick();
    idle();
    total++;
    if (iss_valid !== 1'b1 || iss_pc !== 32'h300) begin
      bad++;
      $display("[TB] FAIL age_first got v=%b pc=%h exp v=1 pc=300", iss_valid, iss_pc);
    end
    tick();
    total++;
    if (iss_valid !== 1'b1 || iss_pc !== 32'h2f0 || iss_v1 !== 32'h55) begin
      bad++;
      $display("[TB] FAIL age_second got v=%b pc=%h v1=%h exp v=1 pc=2f0 v1=55", iss_valid, iss_pc, iss_v1);
    end
  endtask

  task automatic test_bypass();
    drain();
    drive_disp(32'h400, 0, 32'h3, 32'h30, 0);
    bc_valid = 2'b01;
    bc_tag   = {32'h0, 32'h30};
    bc_data  = {32'h0, 32'd9};
    tick();
    idle();
    tick();
    total++;
    if (iss_valid !== 1'b1 || iss_v2 !== 32'd9 || iss_pc !== 32'h400) begin
      bad++;
      $display("[TB] FAIL bypass got v=%b v2=%h pc=%h exp v=1 v2=9 pc=400", iss_valid, iss_v2, iss_pc);
    end
  endtask

  task automatic test_multi_bc();
    drain();
    drive_disp(32'h500, 32'h40, 0, 0, 32'h6);
    tick();
    idle();
    bc_valid = 2'b11;
    bc_tag   = {32'h40, 32'h40};
    bc_data  = {32'd2, 32'd1};
    tick();
    idle();
    tick();
    total++;
    if (iss_valid !== 1'b1 || iss_v1 !== 32'd1 || iss_pc !== 32'h500) begin
      bad++;
      $display("[TB] FAIL multi_bc got v=%b v1=%h pc=%h exp v=1 v1=1 pc=500", iss_valid, iss_v1, iss_pc);
    end
  endtask

  task automatic test_full();
    drain();
    iss_ready = 1'b0;
    for (int n = 0; n < 9; n++) begin
      drive_disp(32'h200 + 32'(4*n), 0, 32'(n), 0, 32'(n+16));
      tick();
      total++;
      if (count !== 4'(mq.size()) || almost_full !== (mq.size() + 3 >= 8)) begin
        bad++;
        $display("[TB] FAIL fill_count n=%0d got c=%0d af=%b exp c=%0d af=%b",
                 n, count, almost_full, mq.size(), (mq.size() + 3 >= 8));
      end
    end
    total++;
    if (count !== 4'd8 || disp_ready !== 1'b0 || almost_full !== 1'b1) begin
      bad++;
      $display("[TB] FAIL full_flags got c=%0d rdy=%b af=%b exp c=8 rdy=0 af=1", count, disp_ready, almost_full);
    end
    drive_disp(32'h2ff, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) begin
      tick();
      idle();
      total++;
      if (count !== 4'd8 || iss_valid !== 1'b1 || iss_pc !== 32'h200 || iss_v2 !== 32'd16) begin
        bad++;
        $display("[TB] FAIL stall_hold n=%0d got c=%0d v=%b pc=%h exp c=8 v=1 pc=200", n, count, iss_valid, iss_pc);
      end
    end
    iss_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      total++;
      if (iss_valid !== 1'b1 || iss_pc !== 32'h200 + 32'(4*k)) begin
        bad++;
        $display("[TB] FAIL drain_order k=%0d got v=%b pc=%h exp v=1 pc=%h", k, iss_valid, iss_pc, 32'h200 + 32'(4*k));
      end
      tick();
    end
    total++;
    if (iss_valid !== 1'b0 || count !== 4'd0) begin
      bad++;
      $display("[TB] FAIL drain_empty got v=%b c=%0d exp v=0 c=0", iss_valid, count);
    end
  endtask

  task automatic test_flush();
    drain();
    iss_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      drive_disp(32'h600 + 32'(4*n), (n == 3) ? 32'h50 : 32'h0, 0, 0, 0);
      tick();
    end
    total++;
    if (count !== 4'd4 || iss_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL preflush got c=%0d v=%b exp c=4 v=1", count, iss_valid);
    end
    drive_disp(32'h700, 32'h50, 0, 0, 0);
    flush    = 1'b1;
    bc_valid = 2'b01;
    bc_tag   = {32'h0, 32'h50};
    bc_data  = {32'h0, 32'h77};
    tick();
    idle();
    total++;
    if (count !== 4'd0 || iss_valid !== 1'b0 || disp_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL flush got c=%0d v=%b rdy=%b exp c=0 v=0 rdy=1", count, iss_valid, disp_ready);
    end
    iss_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      total++;
      if (iss_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL post_flush n=%0d got v=%b exp v=0", n, iss_valid);
      end
    end
    iss_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      drive_disp(32'h800 + 32'(4*n), 0, 32'h1, 0, 32'h2);
      tick();
    end
    idle();
    rst = 1'b0;
    #1;
    mq.delete();
    m_valid = 1'b0;
    m_out   = '0;
    total++;
    if (iss_valid !== 1'b0 || count !== 4'd0 || iss_pc !== 32'd0 || iss_v1 !== 32'd0 || almost_full !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset got v=%b c=%0d pc=%h v1=%h exp all zero", iss_valid, count, iss_pc, iss_v1);
    end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_random();
    drain();
    for (int n = 0; n < 600; n++) begin
      flush      = ($urandom_range(0, 79) == 0);
      iss_ready  = ($urandom_range(0, 9) < 7);
      disp_valid = $urandom_range(0, 1);
      disp_op    = 6'($urandom);
      disp_pc    = $urandom;
      disp_imm   = $urandom;
      disp_v1    = $urandom;
      disp_v2    = $urandom;
      disp_q1    = ($urandom_range(0, 9) < 4) ? 32'($urandom_range(1, 6)) : 32'h0;
      disp_q2    = ($urandom_range(0, 9) < 4) ? 32'($urandom_range(1, 6)) : 32'h0;
      bc_valid   = 2'($urandom);
      bc_tag     = {32'($urandom_range(0, 6)), 32'($urandom_range(0, 6))};
      bc_data    = {32'($urandom), 32'($urandom)};
      tick();
      total++;
      if (iss_valid !== m_valid) begin
        bad++;
        $display("[TB] FAIL rnd_valid cyc=%0d got=%b exp=%b", n, iss_valid, m_valid);
      end
      if (m_valid) begin
        total++;
        if ({iss_op, iss_pc, iss_imm, iss_v1, iss_v2} !== {m_out.op, m_out.pc, m_out.imm, m_out.v1, m_out.v2}) begin
          bad++;
          $display("[TB] FAIL rnd_fields cyc=%0d got op=%h pc=%h imm=%h v1=%h v2=%h exp op=%h pc=%h imm=%h v1=%h v2=%h",
                   n, iss_op, iss_pc, iss_imm, iss_v1, iss_v2,
                   m_out.op, m_out.pc, m_out.imm, m_out.v1, m_out.v2);
        end
      end
      total++;
      if (count !== 4'(mq.size()) || disp_ready !== (mq.size() != 8) || almost_full !== (mq.size() + 3 >= 8)) begin
        bad++;
        $display("[TB] FAIL rnd_occupancy cyc=%0d got c=%0d rdy=%b af=%b exp c=%0d", n, count, disp_ready, almost_full, mq.size());
      end
    end
    idle();
  endtask

  initial begin
    m_valid = 1'b0;
    m_out   = '0;
    test_reset();
    test_basic();
    test_age();
    test_bypass();
    test_multi_bc();
    test_full();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
